bus_mem_responder: RTL and testbench

BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

---
 rtl/sc64_bus_pkg.sv | 29 ++
 rtl/bus_mem_ram.sv | 26 ++
 rtl/bus_mem_responder.sv | 102 ++++++++++
 tb/tb_bus_mem_responder.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sc64_bus_pkg.sv
// Shared SC64 bus definitions: bank IDs, default wait states and responder FSM/request types.
package sc64_bus_pkg;

  localparam logic [3:0] BANK_ROM   = 4'd0;
  localparam logic [3:0] BANK_SDRAM = 4'd1;
  localparam logic [3:0] BANK_CART  = 4'd2;
  localparam logic [3:0] BANK_IO    = 4'd3;

  localparam int DEFAULT_WAIT_STATES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ACK
  } mem_state_t;

  typedef struct packed {
    logic        write;
    logic [3:0]  bank;
    logic [31:0] data;
  } mem_req_t;

  // Counter preload so that the WAIT state lasts exactly ws cycles.
  function automatic logic [3:0] wait_load(input int ws);
    return (ws > 0) ? 4'(ws - 1) : 4'd0;
  endfunction

endpackage

// File: rtl/bus_mem_ram.sv
// Single-port synchronous RAM, write-first, one-cycle read latency; contents are never reset.
module bus_mem_ram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_write,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [31:0]           i_data,
  output logic [31:0]           o_data
);

  logic [31:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_write) begin
        mem[i_addr] <= i_data;
        o_data      <= i_data;
      end else begin
        o_data <= mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Bank-addressed memory responder: accepts one request when idle, waits WAIT_STATES cycles,
// accesses RAM, then pulses o_ack; o_busy holds the initiator off until the request completes.
module bus_mem_responder
  import sc64_bus_pkg::*;
#(
  parameter logic [3:0] BANK        = BANK_SDRAM,
  parameter int         DEPTH_LOG2  = 10,
  parameter int         WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_request,
  input  logic        i_write,
  input  logic [3:0]  i_bank,
  input  logic [25:0] i_address,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_bank_miss
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_STATES);

  mem_state_t            state, state_next;
  mem_req_t              req;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [3:0]            wait_cnt;
  logic                  busy, bank_miss;
  logic [31:0]           data_hold, ram_rdata;
  logic                  accept, hit, ram_en;

  assign accept      = i_request && (state == ST_IDLE);
  assign hit         = (req.bank == BANK);
  assign o_busy      = busy;
  assign o_bank_miss = bank_miss;

  always_comb begin
    state_next = state;
    o_ack      = 1'b0;
    o_data     = data_hold;
    ram_en     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_next = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd0) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        ram_en     = hit;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        o_ack = 1'b1;
        if (!req.write) o_data = hit ? ram_rdata : 32'hFFFF_FFFF;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      bank_miss <= 1'b0;
      wait_cnt  <= 4'd0;
      data_hold <= 32'h0;
    end else begin
      state <= state_next;
      busy  <= (state_next != ST_IDLE);
      if (accept) begin
        bank_miss <= bank_miss | (i_bank != BANK);
        wait_cnt  <= WAIT_LOAD;
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Keep the last presented word so o_data is stable after a write ack.
      if (state == ST_ACK) data_hold <= o_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      req      <= '{write: i_write, bank: i_bank, data: i_data};
      word_idx <= i_address[DEPTH_LOG2+1:2];
    end
  end

  bus_mem_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (ram_en),
    .i_write (req.write),
    .i_addr  (word_idx),
    .i_data  (req.data),
    .o_data  (ram_rdata)
  );

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench: instance A (WAIT_STATES=2, DEPTH_LOG2=4, BANK=1) and instance B (WAIT_STATES=0).
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_wr;
  logic [3:0]  a_bank;
  logic [25:0] a_addr;
  logic [31:0] a_wdata, a_rdata;
  logic        a_busy, a_ack, a_miss;
  logic        b_req, b_wr;
  logic [3:0]  b_bank;
  logic [25:0] b_addr;
  logic [31:0] b_wdata, b_rdata;
  logic        b_busy, b_ack, b_miss;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bus_mem_responder #(.BANK(4'd1), .DEPTH_LOG2(4), .WAIT_STATES(2)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_request(a_req), .i_write(a_wr), .i_bank(a_bank),
    .i_address(a_addr), .i_data(a_wdata), .o_busy(a_busy), .o_ack(a_ack),
    .o_data(a_rdata), .o_bank_miss(a_miss)
  );

  bus_mem_responder #(.BANK(4'd1), .DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_request(b_req), .i_write(b_wr), .i_bank(b_bank),
    .i_address(b_addr), .i_data(b_wdata), .o_busy(b_busy), .o_ack(b_ack),
    .o_data(b_rdata), .o_bank_miss(b_miss)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request on instance A; lat = negedges from accept edge to o_ack (0 = timeout).
  task automatic a_xfer(input logic wr, input logic [3:0] bank, input logic [25:0] addr,
                        input logic [31:0] data, output logic [31:0] rd, output int lat);
    @(negedge clk);
    a_req = 1'b1; a_wr = wr; a_bank = bank; a_addr = addr; a_wdata = data;
    @(posedge clk);
    #1 a_req = 1'b0;
    lat = 0;
    rd  = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (a_ack) begin
        lat = i;
        rd  = a_rdata;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, acks, last, sent, cyc;

    rst = 1'b1;
    a_req = 1'b0; a_wr = 1'b0; a_bank = 4'd1; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_bank = 4'd1; b_addr = '0; b_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'b0, a_busy}, 32'd0);
    check("rst_ack",  {31'b0, a_ack},  32'd0);
    check("rst_data", a_rdata, 32'h0);
    check("rst_miss", {31'b0, a_miss}, 32'd0);

    // Basic write then read-back, 4-cycle latency each.
    a_xfer(1'b1, 4'd1, 26'h10, 32'hDEADBEEF, rd, lat);
    check("wr_latency", lat, 32'd4);
    a_xfer(1'b0, 4'd1, 26'h10, 32'h0, rd, lat);
    check("rd_latency", lat, 32'd4);
    check("rd_data", rd, 32'hDEADBEEF);

    // Reset during the second WAIT cycle drops the write.
    @(negedge clk);
    a_req = 1'b1; a_wr = 1'b1; a_bank = 4'd1; a_addr = 26'h10; a_wdata = 32'h0000_0BAD;
    @(posedge clk);
    #1 a_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ack) acks++;
    end
    check("rst_wait_noack", acks, 32'd0);
    check("rst_wait_busy", {31'b0, a_busy}, 32'd0);
    check("rst_wait_data", a_rdata, 32'h0);
    a_xfer(1'b0, 4'd1, 26'h10, 32'h0, rd, lat);
    check("rst_wait_old", rd, 32'hDEADBEEF);

    // Eight back-to-back writes with i_request held high.
    acks = 0; last = -1; sent = 0; cyc = 0;
    while (acks < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (a_ack) begin
        acks++;
        if (last >= 0) check("b2b_spacing", cyc - last, 32'd5);
        last = cyc;
        if (acks == 8) a_req = 1'b0;
      end
      if (!a_busy && acks < 8) begin
        if (sent < 8) begin
          a_req = 1'b1; a_wr = 1'b1; a_bank = 4'd1;
          a_addr = 26'(sent * 4); a_wdata = 32'(sent);
          sent++;
        end else begin
          a_req = 1'b0;
        end
      end
    end
    a_req = 1'b0;
    check("b2b_acks", acks, 32'd8);
    for (int i = 0; i < 8; i++) begin
      a_xfer(1'b0, 4'd1, 26'(i * 4), 32'h0, rd, lat);
      check($sformatf("b2b_rd%0d", i), rd, 32'(i));
    end

    // Bank-miss write: dropped, acked, sticky flag one cycle after accept.
    @(negedge clk);
    check("miss_pre", {31'b0, a_miss}, 32'd0);
    a_req = 1'b1; a_wr = 1'b1; a_bank = 4'd2; a_addr = 26'h10; a_wdata = 32'h5555_5555;
    @(posedge clk);
    #1 a_req = 1'b0;
    @(negedge clk);
    check("miss_flag_t1", {31'b0, a_miss}, 32'd1);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_ack) acks++;
    end
    check("miss_wr_ack", acks, 32'd1);
    a_xfer(1'b0, 4'd1, 26'h10, 32'h0, rd, lat);
    check("miss_wr_dropped", rd, 32'd4);

    // Bank-miss read returns all ones.
    a_xfer(1'b0, 4'd3, 26'h10, 32'h0, rd, lat);
    check("miss_rd_lat", lat, 32'd4);
    check("miss_rd_data", rd, 32'hFFFF_FFFF);
    check("miss_sticky", {31'b0, a_miss}, 32'd1);

    // Word index wraps modulo 16.
    a_xfer(1'b1, 4'd1, 26'h40, 32'h0000_1234, rd, lat);
    a_xfer(1'b0, 4'd1, 26'h00, 32'h0, rd, lat);
    check("wrap_rd", rd, 32'h0000_1234);

    // Zero wait states: ack at T+2, new request at T+3 accepted.
    @(negedge clk);
    b_req = 1'b1; b_wr = 1'b1; b_bank = 4'd1; b_addr = 26'h8; b_wdata = 32'hCAFE_0001;
    @(posedge clk);
    #1 b_req = 1'b0;
    @(negedge clk);
    check("ws0_t1_ack", {31'b0, b_ack}, 32'd0);
    check("ws0_t1_busy", {31'b0, b_busy}, 32'd1);
    @(negedge clk);
    check("ws0_t2_ack", {31'b0, b_ack}, 32'd1);
    @(negedge clk);
    check("ws0_t3_busy", {31'b0, b_busy}, 32'd0);
    b_req = 1'b1; b_wr = 1'b0; b_addr = 26'h8;
    @(posedge clk);
    #1 b_req = 1'b0;
    check("ws0_accept2", {31'b0, b_busy}, 32'd1);
    @(negedge clk);
    check("ws0_t4_ack", {31'b0, b_ack}, 32'd0);
    @(negedge clk);
    check("ws0_t5_ack", {31'b0, b_ack}, 32'd1);
    check("ws0_rd_data", b_rdata, 32'hCAFE_0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
